// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, multi-cycle memory between the
// FETCH stage (instruction reads) and the MEMORY stage (loads/stores).
// Data accesses win over instruction fetches. A served bit per requester
// keeps a request that stays high during a freeze from being served twice.
// stopCPU holds the pipeline until every request of the step is served.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic [DATA_W-1:0] ifRdata,
   input  logic              dmReq,
   input  logic              dmWe,
   input  logic [ADDR_W-1:0] dmAddr,
   input  logic [DATA_W-1:0] dmWdata,
   output logic [DATA_W-1:0] dmRdata,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic              stopCPU,
   output logic              memErr
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY_D = 2'b01,
      ST_BUSY_I = 2'b10
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_dm_rdata;
   logic                r_mem_err;
   logic                r_if_served;
   logic                r_dm_served;

   logic                w_if_pend;
   logic                w_dm_pend;
   logic                w_stop;
   logic                w_cnt_last;
   logic                w_grant_d;
   logic                w_grant_i;
   logic                w_done;
   logic                w_busy;
   logic [DATA_W-1:0]   w_rd_data;

   // A requester is pending while it asks and has not yet been served this step.
   assign w_if_pend  = ifReq & ~r_if_served;
   assign w_dm_pend  = dmReq & ~r_dm_served;
   assign w_stop     = w_if_pend | w_dm_pend;
   assign w_busy     = (r_state == ST_BUSY_D) || (r_state == ST_BUSY_I);
   // The last busy cycle before a forced completion: memReq stays up exactly TIMEOUT cycles.
   assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
   // A timed-out access completes with all-zero read data.
   assign w_rd_data  = memAck ? memRdata : {DATA_W{1'b0}};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus grant/completion strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_d   = 1'b0;
      w_grant_i   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_dm_pend) begin
               w_state_nxt = ST_BUSY_D;
               w_grant_d   = 1'b1;
            end else if (w_if_pend) begin
               w_state_nxt = ST_BUSY_I;
               w_grant_i   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY_D, ST_BUSY_I: begin
            if (memAck || w_cnt_last) begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Memory handshake registers: latched on grant, stable while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= {DATA_W{1'b0}};
      end else if (w_grant_d) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= dmWe;
         r_mem_addr  <= dmAddr;
         r_mem_wdata <= dmWdata;
      end else if (w_grant_i) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= ifAddr;
      end else if (w_done) begin
         r_mem_req   <= 1'b0;
      end
   end

   // Busy-cycle counter used for the acknowledge timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_grant_d || w_grant_i || w_done) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_busy) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Read-data holding registers; stores leave the load data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_rdata <= {DATA_W{1'b0}};
         r_dm_rdata <= {DATA_W{1'b0}};
      end else if (w_done && (r_state == ST_BUSY_I)) begin
         r_if_rdata <= w_rd_data;
      end else if (w_done && (r_state == ST_BUSY_D) && !r_mem_we) begin
         r_dm_rdata <= w_rd_data;
      end
   end

   // Sticky error flag, set by any forced (timed-out) completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_err <= 1'b0;
      end else if (w_done && !memAck) begin
         r_mem_err <= 1'b1;
      end
   end

   // Served bits: set on completion, cleared whenever the pipeline advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_served <= 1'b0;
         r_dm_served <= 1'b0;
      end else begin
         if (w_done && (r_state == ST_BUSY_I)) begin
            r_if_served <= 1'b1;
         end else if (!w_stop) begin
            r_if_served <= 1'b0;
         end
         if (w_done && (r_state == ST_BUSY_D)) begin
            r_dm_served <= 1'b1;
         end else if (!w_stop) begin
            r_dm_served <= 1'b0;
         end
      end
   end

   assign memReq   = r_mem_req;
   assign memWe    = r_mem_we;
   assign memAddr  = r_mem_addr;
   assign memWdata = r_mem_wdata;
   assign ifRdata  = r_if_rdata;
   assign dmRdata  = r_dm_rdata;
   assign memErr   = r_mem_err;
   assign stopCPU  = w_stop;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants,
// completions and freeze lengths; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      bit          chk_wd;
   } grant_t;

   typedef struct {
      logic [31:0] if_rd;
      logic [31:0] dm_rd;
      logic        err;
   } cmpl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifReq = 1'b0;
   logic [31:0] ifAddr = 32'h0;
   logic [31:0] ifRdata;
   logic        dmReq = 1'b0;
   logic        dmWe = 1'b0;
   logic [31:0] dmAddr = 32'h0;
   logic [31:0] dmWdata = 32'h0;
   logic [31:0] dmRdata;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata = 32'h0;
   logic        memAck = 1'b0;
   logic        stopCPU;
   logic        memErr;

   grant_t exp_grant[$];
   cmpl_t  exp_cmpl[$];
   int     exp_frz[$];

   int n_vec  = 0;
   int n_miss = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata),
      .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata), .dmRdata(dmRdata),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memAck(memAck), .stopCPU(stopCPU), .memErr(memErr)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: event did not occur as required", name);
   endfunction

   // Monitor state
   bit     prev_req = 1'b0;
   bit     busy = 1'b0;
   int     frz_len = 0;
   grant_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
         busy     = 1'b0;
         frz_len  = 0;
      end else begin
         if (memReq && !prev_req) begin
            if (exp_grant.size() == 0) begin
               fail_now("unexpected_grant");
            end else begin
               cur  = exp_grant.pop_front();
               busy = 1'b1;
            end
         end
         if (memReq && busy) begin
            chk("memAddr", memAddr, cur.addr);
            chk("memWe", {31'h0, memWe}, {31'h0, cur.we});
            if (cur.chk_wd) chk("memWdata", memWdata, cur.wdata);
         end
         if (!memReq && prev_req) begin
            busy = 1'b0;
            if (exp_cmpl.size() == 0) begin
               fail_now("unexpected_completion");
            end else begin
               cmpl_t c;
               c = exp_cmpl.pop_front();
               chk("ifRdata", ifRdata, c.if_rd);
               chk("dmRdata", dmRdata, c.dm_rd);
               chk("memErr", {31'h0, memErr}, {31'h0, c.err});
            end
         end
         prev_req = memReq;
         if (stopCPU) begin
            frz_len++;
         end else if (frz_len != 0) begin
            if (exp_frz.size() == 0) begin
               fail_now("unexpected_freeze");
            end else begin
               chk("freeze_len", 32'(frz_len), 32'(exp_frz.pop_front()));
            end
            frz_len = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (memReq) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("grant_wait");
   endtask

   // Called in the first memReq cycle; ack sampled k edges after memReq rose.
   task automatic ack_after(int k, logic [31:0] d);
      repeat (k - 1) tick();
      memAck   = 1'b1;
      memRdata = d;
      tick();
      memAck   = 1'b0;
      memRdata = 32'h0;
   endtask

   task automatic push_g(logic [31:0] a, logic we, logic [31:0] wd, bit cw);
      grant_t g;
      g.addr = a; g.we = we; g.wdata = wd; g.chk_wd = cw;
      exp_grant.push_back(g);
   endtask

   task automatic push_c(logic [31:0] ir, logic [31:0] dr, logic e);
      cmpl_t c;
      c.if_rd = ir; c.dm_rd = dr; c.err = e;
      exp_cmpl.push_back(c);
   endtask

   initial begin
      // Reset values
      repeat (3) tick();
      chk("rst_memReq", {31'h0, memReq}, 32'h0);
      chk("rst_stopCPU", {31'h0, stopCPU}, 32'h0);
      chk("rst_ifRdata", ifRdata, 32'h0);
      chk("rst_memAddr", memAddr, 32'h0);
      rst_n = 1'b1;
      tick();

      // Single IF read, ack 3 cycles after memReq
      ifReq = 1'b1; ifAddr = 32'h40;
      push_g(32'h40, 1'b0, 32'h0, 1'b0);
      push_c(32'h8C220004, 32'h0, 1'b0);
      exp_frz.push_back(4);
      wait_grant();
      ack_after(3, 32'h8C220004);
      ifReq = 1'b0;
      repeat (2) tick();

      // Collision: data first, then instruction
      ifReq = 1'b1; ifAddr = 32'h04;
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h100;
      push_g(32'h100, 1'b0, 32'h0, 1'b0);
      push_g(32'h04, 1'b0, 32'h0, 1'b0);
      push_c(32'h8C220004, 32'h11111111, 1'b0);
      push_c(32'h5A5A0002, 32'h11111111, 1'b0);
      exp_frz.push_back(6);
      wait_grant();
      ack_after(2, 32'h11111111);
      wait_grant();
      ack_after(2, 32'h5A5A0002);
      ifReq = 1'b0; dmReq = 1'b0;
      repeat (2) tick();

      // Store; requester inputs change mid-access and must be ignored
      dmReq = 1'b1; dmWe = 1'b1; dmWdata = 32'hDEADBEEF; dmAddr = 32'h200;
      push_g(32'h200, 1'b1, 32'hDEADBEEF, 1'b1);
      push_c(32'h5A5A0002, 32'h11111111, 1'b0);
      exp_frz.push_back(4);
      wait_grant();
      dmAddr = 32'h999; dmWdata = 32'h0;
      ack_after(3, 32'hBAD0BAD0);
      dmReq = 1'b0; dmWe = 1'b0;
      repeat (2) tick();

      // memAck in IDLE is ignored
      memAck = 1'b1; memRdata = 32'hFFFFFFFF;
      tick();
      memAck = 1'b0; memRdata = 32'h0;
      tick();
      chk("idle_ack_ifRdata", ifRdata, 32'h5A5A0002);
      chk("idle_ack_dmRdata", dmRdata, 32'h11111111);
      chk("idle_ack_memReq", {31'h0, memReq}, 32'h0);

      // No double service: ifReq held through the freeze after its ack
      ifReq = 1'b1; ifAddr = 32'h08;
      push_g(32'h08, 1'b0, 32'h0, 1'b0);
      push_g(32'h104, 1'b0, 32'h0, 1'b0);
      push_c(32'h20020008, 32'h11111111, 1'b0);
      push_c(32'h20020008, 32'h30030104, 1'b0);
      exp_frz.push_back(6);
      wait_grant();
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h104;
      ack_after(2, 32'h20020008);
      chk("frozen_after_if_ack", {31'h0, stopCPU}, 32'h1);
      wait_grant();
      ack_after(2, 32'h30030104);
      dmReq = 1'b0; ifAddr = 32'h0C;
      #1;
      chk("advance_stopCPU", {31'h0, stopCPU}, 32'h0);
      tick();
      chk("served_cleared", {31'h0, stopCPU}, 32'h1);

      // Timeout on the held IF request (TIMEOUT=4, no ack)
      push_g(32'h0C, 1'b0, 32'h0, 1'b0);
      push_c(32'h0, 32'h30030104, 1'b1);
      exp_frz.push_back(5);
      wait_grant();
      repeat (4) tick();
      chk("timeout_memReq", {31'h0, memReq}, 32'h0);
      ifReq = 1'b0;
      repeat (3) tick();
      chk("memErr_sticky", {31'h0, memErr}, 32'h1);

      // Next request after timeout proceeds normally
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h300;
      push_g(32'h300, 1'b0, 32'h0, 1'b0);
      push_c(32'h0, 32'h0BADF00D, 1'b1);
      exp_frz.push_back(2);
      wait_grant();
      ack_after(1, 32'h0BADF00D);
      dmReq = 1'b0;
      repeat (2) tick();

      // Reset in the middle of a BUSY_D access
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h400;
      push_g(32'h400, 1'b0, 32'h0, 1'b0);
      wait_grant();
      tick();
      rst_n = 1'b0; dmReq = 1'b0;
      #1;
      chk("mid_rst_memReq", {31'h0, memReq}, 32'h0);
      chk("mid_rst_memWe", {31'h0, memWe}, 32'h0);
      chk("mid_rst_memAddr", memAddr, 32'h0);
      chk("mid_rst_memWdata", memWdata, 32'h0);
      chk("mid_rst_dmRdata", dmRdata, 32'h0);
      chk("mid_rst_ifRdata", ifRdata, 32'h0);
      chk("mid_rst_memErr", {31'h0, memErr}, 32'h0);
      chk("mid_rst_stopCPU", {31'h0, stopCPU}, 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Fresh request after reset release
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h404;
      push_g(32'h404, 1'b0, 32'h0, 1'b0);
      push_c(32'h0, 32'h12345678, 1'b0);
      exp_frz.push_back(3);
      wait_grant();
      ack_after(2, 32'h12345678);
      dmReq = 1'b0;
      repeat (4) tick();

      chk("left_grants", 32'(exp_grant.size()), 32'h0);
      chk("left_completions", 32'(exp_cmpl.size()), 32'h0);
      chk("left_freezes", 32'(exp_frz.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
